// File: rtl/hmm_seq_gen.sv
// Markov-chain sequence generator.
// Walks a left-to-right hidden chain driven by a Galois LFSR and writes the
// true state (path RAM) and a noisy observation (obs RAM) per step. Both
// RAMs are read back through a registered, one-cycle-latency port.
//
//  state | meaning
//  ------+-------------------------------------------------------------
//  IDLE  | waiting for start; parameters sampled on the accepting edge
//  GEN   | one step per cycle, writing address step_q to both RAMs
//  FIN   | one cycle with done high, then back to IDLE
module hmm_seq_gen #(
  parameter int          T_LEN    = 32,
  parameter int          STATE_W  = 4,
  parameter logic [15:0] POLY     = 16'hB400,
  parameter logic [15:0] SEED_DEF = 16'hACE1,
  parameter int          ADDR_W   = $clog2(T_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [15:0]        seed,
  input  logic [STATE_W-1:0] init_state,
  input  logic [4:0]         p_move,
  input  logic [4:0]         p_err,
  output logic               busy,
  output logic               done,
  input  logic [ADDR_W-1:0]  rd_addr,
  output logic [7:0]         obs_dout,
  output logic [7:0]         path_dout
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_FIN} state_e;

  localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(T_LEN - 1);

  state_e             state_q;
  logic [ADDR_W-1:0]  step_q;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [STATE_W-1:0] init_q, prev_q;
  logic [STATE_W-1:0] s_d, o_d;
  logic [4:0]         p_move_q, p_err_q;
  logic               move, corrupt;
  logic               busy_q, done_q;

  logic [STATE_W-1:0] obs_mem  [T_LEN];
  logic [STATE_W-1:0] path_mem [T_LEN];

  // Current step's state, observation and the next LFSR value.
  // The corruption mask has bit 0 forced so a corrupted obs always differs.
  always_comb begin
    move    = {1'b0, lfsr_q[3:0]} < p_move_q;
    corrupt = {1'b0, lfsr_q[7:4]} < p_err_q;
    s_d     = (step_q == '0) ? init_q : prev_q + STATE_W'(move);
    o_d     = corrupt ? (s_d ^ (lfsr_q[8 +: STATE_W] | STATE_W'(1))) : s_d;
    lfsr_d  = lfsr_q[0] ? ((lfsr_q >> 1) ^ POLY) : (lfsr_q >> 1);
  end

  // Sequencing FSM with registered busy/done; reset aborts any run silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      lfsr_q   <= SEED_DEF;
      init_q   <= '0;
      prev_q   <= '0;
      p_move_q <= '0;
      p_err_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            lfsr_q   <= (seed == 16'h0000) ? SEED_DEF : seed;
            init_q   <= init_state;
            p_move_q <= p_move;
            p_err_q  <= p_err;
            step_q   <= '0;
            busy_q   <= 1'b1;
            state_q  <= S_GEN;
          end
        end
        S_GEN: begin
          prev_q <= s_d;
          lfsr_q <= lfsr_d;
          if (step_q == LAST_STEP) begin
            step_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_FIN;
          end else begin
            step_q <= step_q + 1'b1;
          end
        end
        S_FIN: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // RAM writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (state_q == S_GEN) begin
      obs_mem[step_q]  <= o_d;
      path_mem[step_q] <= s_d;
    end
  end

  // Registered readback; a same-cycle write to rd_addr is not forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      obs_dout  <= '0;
      path_dout <= '0;
    end else begin
      obs_dout  <= {{(8-STATE_W){1'b0}}, obs_mem[rd_addr]};
      path_dout <= {{(8-STATE_W){1'b0}}, path_mem[rd_addr]};
    end
  end

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_hmm_seq_gen.sv
// Bench for hmm_seq_gen: reference model built from the chain rules with
// plain integer arithmetic; readback data checked through a scoreboard.
module tb_hmm_seq_gen;
  localparam int T_LEN = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] seed = '0;
  logic [3:0]  init_state = '0;
  logic [4:0]  p_move = '0;
  logic [4:0]  p_err = '0;
  logic        busy, done;
  logic [4:0]  rd_addr = '0;
  logic [7:0]  obs_dout, path_dout;

  always #5 clk = ~clk;

  hmm_seq_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed),
    .init_state(init_state), .p_move(p_move), .p_err(p_err),
    .busy(busy), .done(done), .rd_addr(rd_addr),
    .obs_dout(obs_dout), .path_dout(path_dout)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int obs;
    int path;
    int addr;
  } exp_t;
  exp_t sb_q[$];

  int  exp_obs  [T_LEN];
  int  exp_path [T_LEN];
  logic rd_req = 1'b0;
  logic rd_req_d = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: chain rules evaluated with integer arithmetic.
  task automatic ref_gen(input int sd, input int ini, input int pm, input int pe);
    int l, s;
    l = (sd == 0) ? 'hACE1 : sd;
    s = ini;
    for (int t = 0; t < T_LEN; t++) begin
      if (t > 0 && (l % 16) < pm) s = (s + 1) % 16;
      exp_path[t] = s;
      if (((l / 16) % 16) < pe) exp_obs[t] = s ^ (((l / 256) % 16) | 1);
      else exp_obs[t] = s;
      if (l % 2 == 1) l = (l / 2) ^ 'hB400;
      else l = l / 2;
    end
  endtask

  // Monitor: a read issued before edge k is compared after edge k.
  always @(posedge clk) rd_req_d <= rd_req;

  always @(negedge clk) begin
    if (rd_req_d) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: got read data %0d with no expected entry", obs_dout);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check($sformatf("obs[%0d]", e.addr), int'(obs_dout), e.obs);
        check($sformatf("path[%0d]", e.addr), int'(path_dout), e.path);
      end
    end
  end

  task automatic read_check();
    exp_t e;
    for (int a = 0; a < T_LEN; a++) begin
      @(negedge clk);
      rd_addr = 5'(a);
      rd_req = 1'b1;
      e.obs = exp_obs[a];
      e.path = exp_path[a];
      e.addr = a;
      sb_q.push_back(e);
    end
    @(negedge clk);
    rd_req = 1'b0;
    for (int i = 0; i < 5 && sb_q.size() != 0; i++) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
  endtask

  task automatic launch(input logic [15:0] sd, input logic [3:0] ini,
                        input logic [4:0] pm, input logic [4:0] pe);
    @(negedge clk);
    seed = sd; init_state = ini; p_move = pm; p_err = pe;
    start = 1'b1;
  endtask

  // One full run; optionally pokes start with different params mid-GEN.
  task automatic run_full(input string tag, input logic [15:0] sd, input logic [3:0] ini,
                          input logic [4:0] pm, input logic [4:0] pe, input bit poke);
    int busy_n, done_n, done_at;
    busy_n = 0; done_n = 0; done_at = -1;
    ref_gen(int'(sd), int'(ini), int'(pm), int'(pe));
    launch(sd, ini, pm, pe);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      if (poke && i == 5) begin
        start = 1'b1; init_state = ini + 4'd5; p_move = 5'd16 - pm;
        p_err = 5'd16 - pe; seed = ~sd;
      end
      if (poke && i == 6) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin done_n++; done_at = i; end
    end
    check({tag, "_busy_cycles"}, busy_n, 32);
    check({tag, "_done_count"}, done_n, 1);
    check({tag, "_done_edge"}, done_at, 32);
    read_check();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy33, busy34, done_n;
    // Reset values
    repeat (2) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_obs_dout", int'(obs_dout), 0);
    check("rst_path_dout", int'(path_dout), 0);
    rst_n = 1'b1;

    // 1: pure ramp
    run_full("ramp", 16'h1234, 4'd0, 5'd16, 5'd0, 1'b0);
    // 2: frozen state
    run_full("stay", 16'hBEEF, 4'd9, 5'd0, 5'd0, 1'b0);
    // 3: always corrupted
    run_full("corrupt", 16'h0001, 4'd3, 5'd0, 5'd16, 1'b0);
    @(negedge clk); rd_addr = 5'd0;
    @(negedge clk); check("corrupt_obs0", int'(obs_dout), 2); rd_addr = 5'd1;
    @(negedge clk); check("corrupt_obs1", int'(obs_dout), 6);
    // 4: zero seed substitutes default
    run_full("seed0", 16'h0000, 4'd2, 5'd8, 5'd4, 1'b0);
    run_full("seedace1", 16'hACE1, 4'd2, 5'd8, 5'd4, 1'b0);
    // 5: start during GEN ignored
    run_full("poke", 16'h3C5A, 4'd7, 5'd0, 5'd0, 1'b1);
    // randomized runs, wrap included via high p_move
    for (int r = 0; r < 4; r++) begin
      logic [15:0] sd;
      sd = (r == 1) ? 16'h0 : 16'($urandom);
      run_full($sformatf("rand%0d", r), sd, 4'($urandom_range(15)),
               5'($urandom_range(16)), 5'($urandom_range(16)), 1'b0);
    end

    // 6: reset mid-GEN over an all-9 RAM
    run_full("pre_rst", 16'h7777, 4'd9, 5'd0, 5'd0, 1'b0);
    launch(16'h5555, 4'd0, 5'd16, 5'd0);
    for (int i = 0; i <= 10; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    @(negedge clk);
    rst_n = 1'b1;
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) done_n++;
    end
    check("abort_no_done", done_n, 0);
    ref_gen(16'h5555, 0, 16, 0);
    for (int t = 10; t < T_LEN; t++) begin exp_path[t] = 9; exp_obs[t] = 9; end
    read_check();
    run_full("post_rst", 16'h5555, 4'd0, 5'd16, 5'd0, 1'b0);

    // start held across FIN re-triggers the cycle after returning to IDLE
    ref_gen(16'h0F0F, 5, 4, 2);
    launch(16'h0F0F, 4'd5, 5'd4, 5'd2);
    busy33 = -1; busy34 = -1; done_n = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clk);
      if (i == 33) busy33 = int'(busy);
      if (i == 34) begin busy34 = int'(busy); start = 1'b0; end
      if (done) done_n++;
    end
    start = 1'b0;
    check("hold_busy_fin_idle", busy33, 0);
    check("hold_busy_retrig", busy34, 1);
    check("hold_done_count", done_n, 2);
    read_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
